// File: rtl/nic.sv
// rtl/nic.sv - NIC with single-entry input/output packet buffers behind a 2-bit processor register map
module nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_BUF  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_STS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_BUF = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_STS = ADDR_WIDTH'(3);

    logic [DATA_WIDTH-1:0] in_buf;
    logic                  in_full;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  out_full;

    logic rd;
    logic wr;
    logic in_capture;
    logic in_clear;
    logic out_accept;
    logic drain;

    assign rd = nicEn & ~nicEnWr;
    assign wr = nicEn & nicEnWr;

    assign net_ri = ~rst & ~in_full;

    assign in_capture = net_si & net_ri;
    assign in_clear   = rd & (addr == ADDR_IN_BUF) & in_full;

    // A write that lands while out_full is set is dropped, even on a drain edge.
    assign out_accept = wr & (addr == ADDR_OUT_BUF) & ~out_full;

    // The router only takes packets on the virtual channel matching the packet's MSB.
    assign drain = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity);

    always_comb begin
        d_out = '0;
        if (rd) begin
            case (addr)
                ADDR_IN_BUF:  d_out = in_buf;
                ADDR_IN_STS:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STS: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:      d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (in_capture) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end else if (in_clear) begin
            in_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (drain) begin
            out_full <= 1'b0;
        end else if (out_accept) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            net_so <= 1'b0;
            net_do <= '0;
        end else if (drain) begin
            net_so <= 1'b1;
            net_do <= out_buf;
        end else begin
            net_so <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nic.sv
// tb/tb_nic.sv - randomized self-checking bench for nic against a behavioural register-map model
module tb_nic;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_in_buf, m_out_buf, m_do;
    logic        m_in_full, m_out_full, m_so;

    nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check combinational and registered outputs, advance the model.
    task automatic cycle(input logic r, input logic en, input logic w, input logic [1:0] a,
                         input logic [63:0] din, input logic si, input logic [63:0] di,
                         input logic ro);
        logic [63:0] exp_dout;
        logic        exp_ri, is_rd;
        logic [63:0] n_in_buf, n_out_buf, n_do;
        logic        n_in_full, n_out_full, n_so;
        rst = r; nicEn = en; nicEnWr = w; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro;
        net_polarity = ~net_polarity;
        #1;
        is_rd  = en && !w;
        exp_ri = !r && !m_in_full;
        exp_dout = 64'd0;
        if (is_rd && a == 2'd0) exp_dout = m_in_buf;
        if (is_rd && a == 2'd1) exp_dout = {63'd0, m_in_full};
        if (is_rd && a == 2'd3) exp_dout = {63'd0, m_out_full};
        check("d_out", d_out, exp_dout);
        check("net_ri", {63'd0, net_ri}, {63'd0, exp_ri});
        check("net_so", {63'd0, net_so}, {63'd0, m_so});
        check("net_do", net_do, m_do);

        n_in_buf = m_in_buf; n_in_full = m_in_full;
        n_out_buf = m_out_buf; n_out_full = m_out_full;
        n_so = 1'b0; n_do = m_do;
        if (r) begin
            n_in_buf = '0; n_in_full = 0; n_out_buf = '0; n_out_full = 0; n_do = '0;
        end else begin
            if (si && exp_ri) begin
                n_in_buf = di; n_in_full = 1;
            end else if (is_rd && a == 2'd0 && m_in_full) begin
                n_in_full = 0;
            end
            if (m_out_full && ro && (m_out_buf[63] == net_polarity)) begin
                n_so = 1; n_do = m_out_buf; n_out_full = 0;
            end
            if (en && w && a == 2'd2 && !m_out_full) begin
                n_out_buf = din; n_out_full = 1;
            end
        end
        @(posedge clk);
        m_in_buf = n_in_buf; m_in_full = n_in_full;
        m_out_buf = n_out_buf; m_out_full = n_out_full;
        m_so = n_so; m_do = n_do;
        @(negedge clk);
    endtask

    task automatic idle(input logic ro);
        cycle(0, 0, 0, 2'd0, 64'd0, 0, 64'd0, ro);
    endtask

    initial begin
        logic seen;
        rst = 1; addr = 0; d_in = 0; nicEn = 0; nicEnWr = 0;
        net_si = 0; net_di = 0; net_ro = 0; net_polarity = 0;
        m_in_buf = 'x; m_out_buf = 'x; m_in_full = 'x; m_out_full = 'x; m_so = 'x; m_do = 'x;
        @(negedge clk);
        @(posedge clk);
        m_in_buf = '0; m_out_buf = '0; m_in_full = 0; m_out_full = 0; m_so = 0; m_do = '0;
        @(negedge clk);

        // Reset then idle
        cycle(1, 0, 0, 2'd0, 64'd0, 0, 64'd0, 0);
        cycle(0, 1, 0, 2'd1, 64'd0, 0, 64'd0, 0);
        check("rst_ri", {63'd0, net_ri}, 64'd1);
        cycle(0, 1, 0, 2'd3, 64'd0, 0, 64'd0, 0);

        // Router ingress, status, read-clear
        cycle(0, 0, 0, 2'd0, 64'd0, 1, 64'hDEAD_BEEF_0000_0001, 0);
        check("ingress_ri", {63'd0, net_ri}, 64'd0);
        cycle(0, 1, 0, 2'd1, 64'd0, 0, 64'd0, 0);
        cycle(0, 1, 0, 2'd0, 64'd0, 0, 64'd0, 0);
        cycle(0, 1, 0, 2'd1, 64'd0, 0, 64'd0, 0);
        cycle(0, 1, 0, 2'd0, 64'd0, 0, 64'd0, 0);

        // Egress with polarity
        cycle(0, 1, 1, 2'd2, 64'h8000_0000_0000_00AA, 0, 64'd0, 1);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            idle(1);
            if (net_so) seen = 1;
        end
        check("egress_seen", {63'd0, seen}, 64'd1);
        check("egress_do", net_do, 64'h8000_0000_0000_00AA);
        cycle(0, 1, 0, 2'd3, 64'd0, 0, 64'd0, 1);

        // Backpressure and dropped second write
        cycle(0, 1, 1, 2'd2, 64'h0000_0000_0000_0011, 0, 64'd0, 0);
        for (int i = 0; i < 5; i++) idle(0);
        cycle(0, 1, 1, 2'd2, 64'h5, 0, 64'd0, 0);
        cycle(0, 1, 0, 2'd3, 64'd0, 0, 64'd0, 0);
        for (int i = 0; i < 4; i++) idle(1);
        cycle(0, 1, 0, 2'd3, 64'd0, 0, 64'd0, 1);

        // Write colliding with a drain, router pushing while full
        cycle(0, 1, 1, 2'd2, 64'h0000_0000_0000_0022, 0, 64'd0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 2'd2, 64'h33, 0, 64'd0, 1);
        cycle(0, 0, 0, 2'd0, 64'd0, 1, 64'h1111, 0);
        cycle(0, 0, 0, 2'd0, 64'd0, 1, 64'h2222, 0);
        cycle(0, 1, 0, 2'd0, 64'd0, 0, 64'd0, 0);

        // Reset mid-send
        cycle(0, 1, 1, 2'd2, 64'h0000_0000_0000_0044, 0, 64'd0, 0);
        cycle(1, 0, 0, 2'd0, 64'd0, 0, 64'd0, 0);
        for (int i = 0; i < 3; i++) idle(1);
        cycle(0, 1, 0, 2'd3, 64'd0, 0, 64'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0), {$urandom, $urandom}, $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
